// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue/collect controller.
package alu_issue_ctrl_pkg;

  // ALU opcodes, carried in action[24:21]
  localparam logic [3:0] OP_ADD    = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_STOREI = 4'b0011;
  localparam logic [3:0] OP_AND    = 4'b0100;
  localparam logic [3:0] OP_OR     = 4'b0101;
  localparam logic [3:0] OP_GEQ    = 4'b0110;
  localparam logic [3:0] OP_LOADD  = 4'b0111;
  localparam logic [3:0] OP_STORE  = 4'b1000;
  localparam logic [3:0] OP_ADDI   = 4'b1001;
  localparam logic [3:0] OP_SUBI   = 4'b1010;
  localparam logic [3:0] OP_LOAD   = 4'b1011;
  localparam logic [3:0] OP_SET    = 4'b1110;

  localparam int PT_W = 16;

  // Tenant page-table entry as presented to the ALU
  typedef struct packed {
    logic [7:0] addr_len;
    logic [7:0] base_addr;
  } page_entry_t;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_page_tbl.sv
// Tenant page table: register file with per-entry valid bits.
// Reads are combinational, so a same-cycle write is seen only next cycle.
module alu_page_tbl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int VID_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [VID_WIDTH-1:0] wr_addr,
  input  page_entry_t          wr_data,
  input  logic [VID_WIDTH-1:0] rd_addr,
  output page_entry_t          rd_data,
  output logic                 rd_valid
);

  localparam int DEPTH = 1 << VID_WIDTH;

  page_entry_t ent_q [DEPTH];
  logic        vld_q [DEPTH];

  // Reset wipes every entry; a config write installs data and marks it valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
        vld_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      ent_q[wr_addr] <= wr_data;
      vld_q[wr_addr] <= 1'b1;
    end
  end

  assign rd_data  = ent_q[rd_addr];
  assign rd_valid = vld_q[rd_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/collect controller for one stage ALU: looks up the tenant page
// entry, issues action+operands, holds them until the result pulse and
// parks the result (or an error) in a one-entry output buffer.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 32,
  parameter int VID_WIDTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ACTION_LEN-1:0] req_action,
  input  logic [DATA_WIDTH-1:0] req_op1,
  input  logic [DATA_WIDTH-1:0] req_op2,
  input  logic [DATA_WIDTH-1:0] req_op3,
  input  logic [VID_WIDTH-1:0]  req_vid,
  output logic [ACTION_LEN-1:0] action_out,
  output logic                  action_valid_out,
  output logic [DATA_WIDTH-1:0] operand_1_out,
  output logic [DATA_WIDTH-1:0] operand_2_out,
  output logic [DATA_WIDTH-1:0] operand_3_out,
  input  logic                  alu_ready_in,
  output logic [PT_W-1:0]       page_tbl_out,
  output logic                  page_tbl_out_valid,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_result_valid,
  output logic                  alu_ready_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [VID_WIDTH-1:0]  res_vid,
  output logic                  res_err,
  input  logic                  cfg_wr_en,
  input  logic [VID_WIDTH-1:0]  cfg_wr_addr,
  input  logic [PT_W-1:0]       cfg_wr_data,
  output logic                  timeout_sticky
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic                 accept;
  logic                 do_result;
  logic                 do_timeout;
  logic                 wd_expired;
  logic [WD_W-1:0]      wdog_q;
  logic [VID_WIDTH-1:0] vid_q;
  page_entry_t          pt_rd_data;
  logic                 pt_rd_valid;

  alu_page_tbl #(.VID_WIDTH(VID_WIDTH)) u_page_tbl (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (cfg_wr_en),
    .wr_addr  (cfg_wr_addr),
    .wr_data  (page_entry_t'(cfg_wr_data)),
    .rd_addr  (req_vid),
    .rd_data  (pt_rd_data),
    .rd_valid (pt_rd_valid)
  );

  assign wd_expired = (wdog_q == WD_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake/strobe outputs; a result pulse beats a
  // coincident watchdog expiry
  always_comb begin
    state_d            = state_q;
    req_ready          = 1'b0;
    action_valid_out   = 1'b0;
    alu_ready_out      = 1'b0;
    page_tbl_out_valid = 1'b0;
    res_valid          = 1'b0;
    accept             = 1'b0;
    do_result          = 1'b0;
    do_timeout         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = alu_ready_in & rst_n;
        accept    = req_valid & req_ready;
        if (accept) state_d = pt_rd_valid ? ST_ISSUE : ST_DRAIN;
      end
      ST_ISSUE: begin
        action_valid_out   = 1'b1;
        alu_ready_out      = 1'b1;
        page_tbl_out_valid = 1'b1;
        state_d            = ST_WAIT;
      end
      ST_WAIT: begin
        alu_ready_out      = 1'b1;
        page_tbl_out_valid = 1'b1;
        if (alu_result_valid) begin
          do_result = 1'b1;
          state_d   = ST_DRAIN;
        end else if (wd_expired) begin
          do_timeout = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue registers: loaded only on accept so the ALU sees stable inputs
  // (including the page entry) for the whole operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      action_out    <= '0;
      operand_1_out <= '0;
      operand_2_out <= '0;
      operand_3_out <= '0;
      page_tbl_out  <= '0;
      vid_q         <= '0;
    end else if (accept) begin
      action_out    <= req_action;
      operand_1_out <= req_op1;
      operand_2_out <= req_op2;
      operand_3_out <= req_op3;
      page_tbl_out  <= pt_rd_data;
      vid_q         <= req_vid;
    end
  end

  // Output buffer: invalid tenant or timeout returns op3 flagged as error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data <= '0;
      res_vid  <= '0;
      res_err  <= 1'b0;
    end else if (accept && !pt_rd_valid) begin
      res_data <= req_op3;
      res_vid  <= req_vid;
      res_err  <= 1'b1;
    end else if (do_result) begin
      res_data <= alu_result;
      res_vid  <= vid_q;
      res_err  <= 1'b0;
    end else if (do_timeout) begin
      res_data <= operand_3_out;
      res_vid  <= vid_q;
      res_err  <= 1'b1;
    end
  end

  // Watchdog: cleared in ISSUE, counts WAIT cycles
  always_ff @(posedge clk) begin
    if (!rst_n)                  wdog_q <= '0;
    else if (state_q == ST_ISSUE) wdog_q <= '0;
    else if (state_q == ST_WAIT)  wdog_q <= wdog_q + 1'b1;
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n)          timeout_sticky <= 1'b0;
    else if (do_timeout) timeout_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: vector table, hand sequences and a randomized
// run against a transaction-level model with an ALU responder.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int TO = 16;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [24:0] req_action;
  logic [31:0] req_op1, req_op2, req_op3;
  logic [3:0]  req_vid;
  logic [24:0] action_out;
  logic        action_valid_out;
  logic [31:0] operand_1_out, operand_2_out, operand_3_out;
  logic        alu_ready_in;
  logic [15:0] page_tbl_out;
  logic        page_tbl_out_valid;
  logic [31:0] alu_result;
  logic        alu_result_valid;
  logic        alu_ready_out;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_vid;
  logic        res_err;
  logic        cfg_wr_en;
  logic [3:0]  cfg_wr_addr;
  logic [15:0] cfg_wr_data;
  logic        timeout_sticky;

  int nvec = 0;
  int nmis = 0;

  alu_issue_ctrl #(.ACTION_LEN(25), .DATA_WIDTH(32), .VID_WIDTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_action(req_action),
    .req_op1(req_op1), .req_op2(req_op2), .req_op3(req_op3), .req_vid(req_vid),
    .action_out(action_out), .action_valid_out(action_valid_out),
    .operand_1_out(operand_1_out), .operand_2_out(operand_2_out), .operand_3_out(operand_3_out),
    .alu_ready_in(alu_ready_in), .page_tbl_out(page_tbl_out), .page_tbl_out_valid(page_tbl_out_valid),
    .alu_result(alu_result), .alu_result_valid(alu_result_valid), .alu_ready_out(alu_ready_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_vid(res_vid),
    .res_err(res_err), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .timeout_sticky(timeout_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  // Behaviour of the ALU itself (used by the responder and the model)
  function automatic logic [31:0] alu_fn(input logic [24:0] act, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c,
                                         input logic [15:0] pe);
    case (act[24:21])
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_GEQ:  return {31'd0, a >= b};
      OP_LOAD: return {16'hA5A5, 16'(b[15:0] + {8'h00, pe[7:0]})};
      default: return a ^ c ^ {16'h0000, pe};
    endcase
  endfunction

  // ALU responder: pulses the result alu_dly cycles after its WAIT starts
  int          alu_dly = 1;
  int          acnt = -1;
  logic        arv_q = 1'b0;
  logic [31:0] ares_q = '0;
  logic        stray = 1'b0;
  logic        cap_live = 1'b0;
  logic [24:0] cap_act;
  logic [31:0] cap_o1, cap_o2, cap_o3;
  logic [15:0] cap_pt;

  assign alu_result       = ares_q;
  assign alu_result_valid = arv_q | stray;

  always @(posedge clk) begin
    arv_q <= 1'b0;
    if (!rst_n) begin
      acnt     <= -1;
      cap_live <= 1'b0;
    end else if (action_valid_out) begin
      cap_act  <= action_out;
      cap_o1   <= operand_1_out;
      cap_o2   <= operand_2_out;
      cap_o3   <= operand_3_out;
      cap_pt   <= page_tbl_out;
      cap_live <= 1'b1;
      acnt     <= (alu_dly == 0) ? -1 : alu_dly;
    end else if (acnt == 1) begin
      arv_q  <= 1'b1;
      ares_q <= alu_fn(cap_act, cap_o1, cap_o2, cap_o3, cap_pt);
      acnt   <= -1;
    end else if (acnt > 1) begin
      acnt <= acnt - 1;
    end
  end

  // The ALU reads its inputs every WAIT cycle; they must match what was issued
  always @(negedge clk) begin
    if (rst_n && cap_live && alu_ready_out && !action_valid_out) begin
      nvec++;
      if ({action_out, operand_1_out, operand_2_out, operand_3_out, page_tbl_out} !==
          {cap_act, cap_o1, cap_o2, cap_o3, cap_pt}) begin
        nmis++;
        $display("FAIL wait_hold got op2=%0h pt=%0h want op2=%0h pt=%0h",
                 operand_2_out, page_tbl_out, cap_o2, cap_pt);
      end
    end
  end

  // Shadow page table and sticky flag for the reference model
  logic [15:0] pt_m [16];
  logic        pv_m [16];
  logic        sticky_m;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    pt_m[a] = d; pv_m[a] = 1'b1;
  endtask

  // Reference: outcome of a request from the tenant table and ALU delay
  task automatic model(input logic [3:0] v, input logic [24:0] act, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input int dly,
                       output logic [31:0] ed, output logic ee, output int el);
    if (!pv_m[v]) begin
      ed = c; ee = 1'b1; el = 1;
    end else if (dly == 0 || dly > TO - 1) begin
      ed = c; ee = 1'b1; el = TO + 2; sticky_m = 1'b1;
    end else begin
      ed = alu_fn(act, a, b, c, pt_m[v]); ee = 1'b0; el = dly + 3;
    end
  endtask

  // One full request: accept, observe issue and result, hold, release
  task automatic do_req(input logic [3:0] v, input logic [24:0] act, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input int dly, input int dw,
                        input bit sc, input logic [3:0] sc_a, input logic [15:0] sc_d,
                        input bit mc, input logic [15:0] mc_d,
                        input logic [31:0] ed, input logic ee, input int el, input logic [15:0] ept);
    int n, k, lat, av_k, av_n;
    logic [15:0] av_pt;
    alu_dly = dly;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1; req_vid = v; req_action = act;
    req_op1 = a; req_op2 = b; req_op3 = c;
    if (sc) begin cfg_wr_en = 1'b1; cfg_wr_addr = sc_a; cfg_wr_data = sc_d; end
    @(negedge clk);
    req_valid = 1'b0;
    if (sc) begin cfg_wr_en = 1'b0; pt_m[sc_a] = sc_d; pv_m[sc_a] = 1'b1; end
    k = 1; lat = -1; av_k = -1; av_n = 0; av_pt = '0;
    while (lat < 0 && k <= 40) begin
      if (action_valid_out) begin
        av_n++;
        if (av_k < 0) begin av_k = k; av_pt = page_tbl_out; end
      end
      if (mc && k == 2) begin cfg_wr_en = 1'b1; cfg_wr_addr = v; cfg_wr_data = mc_d; end
      if (mc && k == 3) begin cfg_wr_en = 1'b0; pt_m[v] = mc_d; pv_m[v] = 1'b1; end
      if (res_valid) lat = k;
      else begin @(negedge clk); k++; end
    end
    if (cfg_wr_en) begin cfg_wr_en = 1'b0; pt_m[v] = mc_d; pv_m[v] = 1'b1; end
    chk("latency", lat, el);
    chk("res_data", res_data, ed);
    chk("res_err", res_err, ee);
    chk("res_vid", res_vid, v);
    chk("alu_ready_out_drain", alu_ready_out, 0);
    if (el == 1) chk("no_issue", av_n, 0);
    else begin
      chk("issue_cycle", av_k, 1);
      chk("issue_page", av_pt, ept);
    end
    res_ready = 1'b0;
    for (int i = 0; i < dw; i++) begin
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, ed);
      chk("hold_req_ready", req_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("release_valid", res_valid, 0);
    chk("release_req_ready", req_ready, 1);
    chk("sticky", timeout_sticky, sticky_m);
  endtask

  typedef struct {
    logic [3:0]  vid;
    logic [3:0]  opc;
    logic [31:0] o1, o2, o3;
    int          dly, dw;
    logic [31:0] ed;
    logic        ee;
    int          el;
    logic [15:0] ept;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int cnt_av, cnt_rv;
    logic [3:0] opl [6];
    opl[0] = OP_ADD; opl[1] = OP_SUB; opl[2] = OP_AND;
    opl[3] = OP_OR;  opl[4] = OP_GEQ; opl[5] = OP_LOAD;

    tbl[0]  = '{4'd2, OP_ADD,  32'd5,      32'd7,      32'd0,      1,  0, 32'd12,       1'b0, 4,  16'h0810};
    tbl[1]  = '{4'd2, OP_SUB,  32'd10,     32'd3,      32'd0,      1,  0, 32'd7,        1'b0, 4,  16'h0810};
    tbl[2]  = '{4'd2, OP_AND,  32'hF0F0,   32'hFF00,   32'd0,      1,  1, 32'hF000,     1'b0, 4,  16'h0810};
    tbl[3]  = '{4'd2, OP_OR,   32'h0F,     32'hF0,     32'd0,      1,  0, 32'hFF,       1'b0, 4,  16'h0810};
    tbl[4]  = '{4'd2, OP_GEQ,  32'd3,      32'd3,      32'd0,      2,  0, 32'd1,        1'b0, 5,  16'h0810};
    tbl[5]  = '{4'd2, OP_GEQ,  32'd2,      32'd3,      32'd0,      1,  0, 32'd0,        1'b0, 4,  16'h0810};
    tbl[6]  = '{4'd2, OP_LOAD, 32'd0,      32'd4,      32'd0,      3,  0, 32'hA5A50014, 1'b0, 6,  16'h0810};
    tbl[7]  = '{4'd5, OP_ADD,  32'd1,      32'd1,      32'hDEAD,   1,  0, 32'hDEAD,     1'b1, 1,  16'h0000};
    tbl[8]  = '{4'd2, OP_ADD,  32'd1,      32'd2,      32'd0,      15, 0, 32'd3,        1'b0, 18, 16'h0810};
    tbl[9]  = '{4'd2, OP_ADD,  32'd1,      32'd2,      32'hBEEF,   16, 0, 32'hBEEF,     1'b1, 18, 16'h0810};
    tbl[10] = '{4'd2, OP_ADD,  32'd1,      32'd2,      32'hCAFE,   0,  0, 32'hCAFE,     1'b1, 18, 16'h0810};
    tbl[11] = '{4'd2, OP_ADD,  32'd100,    32'd200,    32'd0,      1, 10, 32'd300,      1'b0, 4,  16'h0810};

    for (int i = 0; i < 16; i++) begin pt_m[i] = '0; pv_m[i] = 1'b0; end
    sticky_m = 1'b0;
    rst_n = 1'b0; alu_ready_in = 1'b1; req_valid = 1'b0; req_action = '0;
    req_op1 = '0; req_op2 = '0; req_op3 = '0; req_vid = '0; res_ready = 1'b0;
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_action_valid", action_valid_out, 0);
    chk("rst_alu_ready_out", alu_ready_out, 0);
    chk("rst_ptv", page_tbl_out_valid, 0);
    chk("rst_data", {res_data, operand_1_out}, 64'd0);
    chk("rst_sticky_err", {timeout_sticky, res_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);

    // Stray result in IDLE is ignored
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    chk("stray_res_valid", res_valid, 0);
    chk("stray_sticky", timeout_sticky, 0);

    // ALU not ready: no acceptance
    alu_ready_in = 1'b0; req_valid = 1'b1; req_vid = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("aluin_req_ready", req_ready, 0);
      chk("aluin_res_valid", res_valid, 0);
    end
    req_valid = 1'b0; alu_ready_in = 1'b1;
    @(negedge clk);

    // Vector table
    cfg_write(4'd2, 16'h0810);
    cfg_write(4'd3, 16'h0101);
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].ee && tbl[i].el == TO + 2) sticky_m = 1'b1;
      do_req(tbl[i].vid, {tbl[i].opc, 21'd0}, tbl[i].o1, tbl[i].o2, tbl[i].o3, tbl[i].dly,
             tbl[i].dw, 1'b0, 4'd0, 16'd0, 1'b0, 16'd0,
             tbl[i].ed, tbl[i].ee, tbl[i].el, tbl[i].ept);
    end

    // Same-cycle write to the accepted VID: old entry issued, new one next
    do_req(4'd3, {OP_ADD, 21'd0}, 32'd1, 32'd1, 32'd0, 1, 0, 1'b1, 4'd3, 16'h0202,
           1'b0, 16'd0, 32'd2, 1'b0, 4, 16'h0101);
    // In-flight write: issued entry must stay put while WAIT lasts
    do_req(4'd3, {OP_LOAD, 21'd0}, 32'd0, 32'd4, 32'd0, 3, 0, 1'b0, 4'd0, 16'd0,
           1'b1, 16'h0303, 32'hA5A50006, 1'b0, 6, 16'h0202);
    do_req(4'd3, {OP_LOAD, 21'd0}, 32'd0, 32'd4, 32'd0, 1, 0, 1'b0, 4'd0, 16'd0,
           1'b0, 16'd0, 32'hA5A50007, 1'b0, 4, 16'h0303);

    // Reset in the middle of a WAIT: nothing re-issued, table and flags cleared
    alu_dly = 0;
    req_valid = 1'b1; req_vid = 4'd2; req_action = {OP_ADD, 21'd0}; req_op3 = 32'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_alu_ready_out", alu_ready_out, 0);
    chk("midrst_sticky", timeout_sticky, 0);
    chk("midrst_page", page_tbl_out, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin pt_m[i] = '0; pv_m[i] = 1'b0; end
    sticky_m = 1'b0;
    cnt_av = 0; cnt_rv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (action_valid_out) cnt_av++;
      if (res_valid) cnt_rv++;
    end
    chk("midrst_no_reissue", cnt_av, 0);
    chk("midrst_no_result", cnt_rv, 0);
    do_req(4'd2, {OP_ADD, 21'd0}, 32'd1, 32'd1, 32'h55, 1, 0, 1'b0, 4'd0, 16'd0,
           1'b0, 16'd0, 32'h55, 1'b1, 1, 16'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 8; i++) cfg_write(4'(i), 16'($urandom));
    for (int it = 0; it < 40; it++) begin
      logic [3:0]  v, sa;
      logic [24:0] act;
      logic [31:0] a, b, c, ed;
      logic [15:0] sd, md, ept;
      logic        ee;
      bit          sc, mc;
      int          dly, el;
      if ($urandom_range(3) == 0) cfg_write(4'($urandom_range(15)), 16'($urandom));
      v   = 4'($urandom_range(15));
      act = {opl[$urandom_range(5)], 21'($urandom)};
      a = $urandom; b = $urandom; c = $urandom;
      case ($urandom_range(7))
        0: dly = 1; 1: dly = 2; 2: dly = 3; 3: dly = 4;
        4: dly = 15; 5: dly = 16; 6: dly = 0; default: dly = 1;
      endcase
      sc = ($urandom_range(4) == 0);
      sa = 4'($urandom_range(15));
      sd = 16'($urandom);
      mc = pv_m[v] && ($urandom_range(3) == 0);
      md = 16'($urandom);
      ept = pt_m[v];
      model(v, act, a, b, c, dly, ed, ee, el);
      do_req(v, act, a, b, c, dly, int'($urandom_range(2)), sc, sa, sd, mc, md, ed, ee, el, ept);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
